// File: rtl/fetdriver_topsw_gate_seq.sv
// High-side PMOS gate sequencer: break-before-make dead time, min on/off, overcurrent shutdown.
// Build macro FETDRV_FAULT_RETRY_EN: FAULT retries after RETRY cycles; otherwise latched until en=0.
module fetdriver_topsw_gate_seq #(
  parameter int CW       = 8,
  parameter int DEADTIME = 4,
  parameter int MIN_ON   = 6,
  parameter int MIN_OFF  = 8,
  parameter int RETRY    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       pwm_req,
  input  logic       ls_on,
  input  logic       ocp,
  output logic       hs_on,
  output logic       ls_allow,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DT     = 3'd1,
    S_ON     = 3'd2,
    S_MINOFF = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  localparam logic [CW-1:0] DT_LAST      = CW'(DEADTIME - 1);
  localparam logic [CW-1:0] DT_LEN       = CW'(DEADTIME);
  localparam logic [CW-1:0] MIN_ON_LAST  = CW'(MIN_ON - 1);
  localparam logic [CW-1:0] MIN_OFF_LAST = CW'(MIN_OFF - 1);
`ifdef FETDRV_FAULT_RETRY_EN
  localparam logic [CW-1:0] RETRY_LAST   = CW'(RETRY - 1);
`endif

  // A misconfigured instance parks in FAULT so the switch can never be driven on.
  localparam bit PARAMS_OK = (DEADTIME >= 1) && (MIN_ON >= 1) && (RETRY >= 1) &&
                             (MIN_OFF >= DEADTIME) && (MIN_ON < 2**CW) &&
                             (MIN_OFF < 2**CW) && (RETRY < 2**CW);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hs_on_q, hs_on_d;
  logic          ls_allow_q, ls_allow_d;
  logic          fault_q, fault_d;
  logic [CW-1:0] cnt_inc;
  logic          reload;

  always_comb begin
    state_d = state_q;
    reload  = 1'b0;
    cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

    case (state_q)
      S_IDLE: begin
        if (en && pwm_req && !ls_on) state_d = S_DT;
      end
      S_DT: begin
        if (ocp)                   state_d = S_FAULT;
        else if (!en)              state_d = S_IDLE;
        else if (ls_on)            reload  = 1'b1;
        else if (!pwm_req)         state_d = S_IDLE;
        else if (cnt_q == DT_LAST) state_d = S_ON;
      end
      S_ON: begin
        if (ocp) state_d = S_FAULT;
        else if ((cnt_q >= MIN_ON_LAST) && (!en || !pwm_req)) state_d = S_MINOFF;
      end
      S_MINOFF: begin
        if (ocp)                        state_d = S_FAULT;
        else if (cnt_q == MIN_OFF_LAST) state_d = S_IDLE;
      end
      S_FAULT: begin
`ifdef FETDRV_FAULT_RETRY_EN
        if (cnt_q == RETRY_LAST) begin
          if (ocp) reload  = 1'b1;
          else     state_d = S_IDLE;
        end
`else
        if (!ocp && !en) state_d = S_IDLE;
`endif
      end
      default: state_d = S_FAULT;
    endcase

    if (!PARAMS_OK) state_d = S_FAULT;

    cnt_d = ((state_d != state_q) || reload) ? '0 : cnt_inc;

    // Outputs follow the next state so they change on the same edge as the transition.
    hs_on_d    = (state_d == S_ON);
    ls_allow_d = (state_d == S_IDLE) || ((state_d == S_MINOFF) && (cnt_d >= DT_LEN));
    fault_d    = (state_d == S_FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hs_on_q    <= 1'b0;
      ls_allow_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hs_on_q    <= hs_on_d;
      ls_allow_q <= ls_allow_d;
      fault_q    <= fault_d;
    end
  end

  assign hs_on    = hs_on_q;
  assign ls_allow = ls_allow_q;
  assign fault    = fault_q;
  assign state    = state_q;

endmodule
